// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: decides each
// cycle whether pipeline registers advance, hold or take a bubble, covering
// load-use stalls, taken-branch flushes and data-memory wait states.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [18:0]      IF_ID_instruction,
  input  logic [18:0]      ID_EX_instruction,
  input  logic [18:0]      EX_MEM_instruction,
  input  logic             branch_taken,
  input  logic             mem_ack,
  output logic             pc_write,
  output logic             pc_src_branch,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_req,
  output logic             mem_timeout_err,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, ERR = 2'd2} state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            mem_op, load_use, freeze, branch_fire;

  function automatic logic is_lw(input logic [18:0] i);
    return i[18:14] == 5'b10000;
  endfunction

  function automatic logic is_sw(input logic [18:0] i);
    return i[18:14] == 5'b10001;
  endfunction

  // Does instruction i source register r? r0 is hardwired, so never a hazard.
  function automatic logic reads_reg(input logic [18:0] i, input logic [2:0] r);
    logic rd;
    rd = 1'b0;
    if (r != 3'd0) begin
      if (!i[18])        rd = (i[10:8] == r) || ((i[7:5] == r) && !i[17]);
      else if (is_lw(i)) rd = (i[10:8] == r);
      else if (is_sw(i)) rd = (i[10:8] == r) || (i[13:11] == r);
    end
    return rd;
  endfunction

  assign mem_op   = is_lw(EX_MEM_instruction) || is_sw(EX_MEM_instruction);
  assign load_use = is_lw(ID_EX_instruction) &&
                    reads_reg(IF_ID_instruction, ID_EX_instruction[13:11]);

  logic unused_fields;
  assign unused_fields = ^{EX_MEM_instruction[13:0], ID_EX_instruction[10:0]};

  // Pipeline enables: freeze dominates, then branch flush, then load-use bubble.
  always_comb begin
    freeze        = 1'b0;
    pc_write      = 1'b1;
    pc_src_branch = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;
    mem_req       = 1'b0;
    case (state)
      RUN:      begin freeze = mem_op && !mem_ack; mem_req = mem_op; end
      MEM_WAIT: begin freeze = !mem_ack;           mem_req = 1'b1;   end
      default:  begin freeze = 1'b1;               mem_req = 1'b0;   end
    endcase
    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (branch_taken) begin
      pc_src_branch = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
    end else if (load_use) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_bubble  = 1'b1;
    end
  end

  assign branch_fire = !freeze && branch_taken;
  assign ctrl_state  = state;

  // Wait-state FSM, sticky timeout flag and saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      stall_count     <= '0;
      flush_count     <= '0;
    end else begin
      case (state)
        RUN: if (mem_op && !mem_ack) begin
          state    <= MEM_WAIT;
          wait_cnt <= WC_W'(1);
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state <= RUN;
          end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
            state           <= ERR;
            mem_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ERR;
      endcase
      if (!pc_write && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (branch_fire && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl: the driver pushes hand-computed
// expectations per cycle, a monitor on the falling edge pops and compares.
module tb_hazard_stall_ctrl;

  localparam int CW = 4;

  // {pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write,
  //  id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_req}
  localparam logic [8:0] C_RUN  = 9'b101010100;
  localparam logic [8:0] C_MRUN = 9'b101010101;
  localparam logic [8:0] C_LU   = 9'b000011100;
  localparam logic [8:0] C_BR   = 9'b111111100;
  localparam logic [8:0] C_BRM  = 9'b111111101;
  localparam logic [8:0] C_FRZ  = 9'b000000011;
  localparam logic [8:0] C_ERR  = 9'b000000010;
  localparam logic [18:0] NOP   = 19'd0;

  typedef struct {
    logic [8:0]    ctl;
    logic [1:0]    st;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [18:0] ifid = '0, idex = '0, exmem = '0;
  logic br = 1'b0, ack = 1'b0;
  logic pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write;
  logic id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_req, mem_timeout_err;
  logic [1:0] ctrl_state;
  logic [CW-1:0] stall_count, flush_count;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_instruction(ifid), .ID_EX_instruction(idex), .EX_MEM_instruction(exmem),
    .branch_taken(br), .mem_ack(ack),
    .pc_write(pc_write), .pc_src_branch(pc_src_branch),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
    .mem_req(mem_req), .mem_timeout_err(mem_timeout_err),
    .ctrl_state(ctrl_state), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] alu(input logic imm, input int d, input int a, input int b);
    return {1'b0, imm, 3'b000, d[2:0], a[2:0], b[2:0], 5'd0};
  endfunction
  function automatic logic [18:0] lw(input int d, input int a);
    return {5'b10000, d[2:0], a[2:0], 8'd0};
  endfunction
  function automatic logic [18:0] sw(input int d, input int a);
    return {5'b10001, d[2:0], a[2:0], 8'd0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: outputs settle mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ctl", {23'd0, pc_write, pc_src_branch, if_id_write, if_id_flush, id_ex_write,
                  id_ex_bubble, ex_mem_write, mem_wb_bubble, mem_req}, {23'd0, e.ctl});
      chk("state", {30'd0, ctrl_state}, {30'd0, e.st});
      chk("err",   {31'd0, mem_timeout_err}, {31'd0, e.err});
      chk("stall", {28'd0, stall_count}, {28'd0, e.stall});
      chk("flush", {28'd0, flush_count}, {28'd0, e.flush});
    end
  end

  task automatic step(input logic rst, input logic [18:0] i_ifid, input logic [18:0] i_idex,
                      input logic [18:0] i_exmem, input logic i_br, input logic i_ack,
                      input logic [8:0] ctl, input logic [1:0] st, input logic err,
                      input int stall, input int flush);
    exp_t e;
    rst_n = rst; ifid = i_ifid; idex = i_idex; exmem = i_exmem; br = i_br; ack = i_ack;
    e.ctl = ctl; e.st = st; e.err = err; e.stall = stall[CW-1:0]; e.flush = flush[CW-1:0];
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    // reset state
    step(0, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 0, 0);
    step(1, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 0, 0);
    // load-use: LW r3 then add r4=r3+r2 -> single bubble
    step(1, alu(0,4,3,2), lw(3,1), NOP, 0, 0, C_LU, 0, 0, 0, 0);
    step(1, alu(0,4,3,2), NOP, NOP, 0, 0, C_RUN, 0, 0, 1, 0);
    // r0 never hazards; immediate form ignores B
    step(1, alu(0,4,0,0), lw(0,1), NOP, 0, 0, C_RUN, 0, 0, 1, 0);
    step(1, alu(1,4,1,3), lw(3,1), NOP, 0, 0, C_RUN, 0, 0, 1, 0);
    // SW reads DST; LW reads A
    step(1, sw(3,1), lw(3,1), NOP, 0, 0, C_LU, 0, 0, 1, 0);
    step(1, lw(2,5), lw(5,1), NOP, 0, 0, C_LU, 0, 0, 2, 0);
    // taken branch in RUN
    step(1, NOP, NOP, NOP, 1, 0, C_BR, 0, 0, 3, 0);
    step(1, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 3, 1);
    // SW waits 3 cycles, branch held pending until ack cycle
    step(1, NOP, NOP, sw(2,1), 0, 0, C_FRZ, 0, 0, 3, 1);
    step(1, NOP, NOP, sw(2,1), 1, 0, C_FRZ, 1, 0, 4, 1);
    step(1, NOP, NOP, sw(2,1), 1, 0, C_FRZ, 1, 0, 5, 1);
    step(1, NOP, NOP, sw(2,1), 1, 1, C_BRM, 1, 0, 6, 1);
    step(1, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 6, 2);
    // zero-wait access: no stall
    step(1, NOP, NOP, lw(1,2), 0, 1, C_MRUN, 0, 0, 6, 2);
    // timeout: 4 wait cycles then ERR
    step(1, NOP, NOP, sw(2,1), 0, 0, C_FRZ, 0, 0, 6, 2);
    for (int i = 0; i < 4; i++)
      step(1, NOP, NOP, sw(2,1), 0, 0, C_FRZ, 1, 0, 7 + i, 2);
    // ERR is permanent and counts stalls until saturation
    for (int i = 0; i < 8; i++)
      step(1, NOP, NOP, sw(2,1), i[0], i[1], C_ERR, 2, 1, (11 + i > 15) ? 15 : 11 + i, 2);
    // async reset from ERR
    step(0, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 0, 0);
    step(1, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 0, 0);
    // async reset mid-MEM_WAIT
    step(1, NOP, NOP, sw(2,1), 0, 0, C_FRZ, 0, 0, 0, 0);
    step(1, NOP, NOP, sw(2,1), 0, 0, C_FRZ, 1, 0, 1, 0);
    step(0, NOP, NOP, sw(2,1), 0, 0, C_FRZ, 0, 0, 0, 0);
    step(1, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 0, 0);
    step(1, NOP, NOP, NOP, 0, 0, C_RUN, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
